// File: rtl/led_pkg.sv
// led_pkg: shared types and helpers for the breathing-LED sequencer.
//   state_e      : sequencer state (IDLE, UP, HOLD, DOWN), 2-bit encoding
//   PWM_W_DEF    : default PWM counter / duty width
//   DUTY_MAX_DEF : default peak duty
//   gamma_map()  : square-law duty mapping, (d*d) >> w, for w <= 16
package led_pkg;

  localparam int PWM_W_DEF    = 8;
  localparam int DUTY_MAX_DEF = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_HOLD = 2'd2,
    S_DOWN = 2'd3
  } state_e;

  // The square is formed at full width before shifting, so no product bits are lost.
  function automatic logic [15:0] gamma_map(input logic [15:0] d, input int w);
    logic [31:0] sq;
    sq = 32'(d) * 32'(d);
    return 16'(sq >> w);
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// led_pwm_gen: shared free-running PWM counter with a registered compare.
//   clk, rst   : clock, synchronous active-high reset
//   en         : compare enable (sequencer busy)
//   duty_eff   : effective duty compared against the counter
//   pwm        : registered en && (cnt < duty_eff), one clk behind the counter
//   period_end : high while the counter sits at 2^PWM_W-1
module led_pwm_gen #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PWM_W-1:0] duty_eff,
  output logic             pwm,
  output logic             period_end
);

  logic [PWM_W-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;   // wraps naturally at 2^PWM_W
    pwm_d = en && (cnt_q < duty_eff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
    end
  end

  assign period_end = (cnt_q == {PWM_W{1'b1}});
  assign pwm        = pwm_q;

endmodule

// File: rtl/led_breath_seq.sv
// led_breath_seq: chase-breathing sequencer. One channel at a time ramps up,
// holds at DUTY_MAX for HOLD_PER PWM periods, ramps down, then after one dark
// period the next channel starts. A stop finishes the current channel, then idles.
//   clk, rst : clock, synchronous active-high reset
//   start    : one-cycle request to begin (ignored while busy, or with stop)
//   stop     : one-cycle request to finish the current channel, then go idle
//   led      : LED drive, only led[cur_ch] may be on
//   busy     : high while not IDLE
//   cur_ch   : channel currently breathing
//   duty     : raw (unmapped) duty of the active channel
//   done     : one-cycle pulse on return to IDLE, coincident with busy falling
// Build option: define LED_SEQ_GAMMA_EN to drive the PWM with (duty*duty)>>PWM_W
// instead of the linear duty.
module led_breath_seq
  import led_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int PWM_W    = PWM_W_DEF,
  parameter int DUTY_MAX = DUTY_MAX_DEF,
  parameter int HOLD_PER = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  output logic [N_CH-1:0]         led,
  output logic                    busy,
  output logic [$clog2(N_CH)-1:0] cur_ch,
  output logic [PWM_W-1:0]        duty,
  output logic                    done
);

  localparam int CW = $clog2(N_CH);
  localparam int HW = (HOLD_PER > 0) ? $clog2(HOLD_PER + 1) : 1;
  localparam bit NO_HOLD = (HOLD_PER == 0);

  state_e           state_q, state_d;
  logic [PWM_W-1:0] duty_q, duty_d, duty_eff;
  logic [CW-1:0]    cur_ch_q, cur_ch_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             stop_pend_q, stop_pend_d;
  logic             done_q, done_d;
  logic             pwm, period_end, busy_w;

  assign busy_w = (state_q != S_IDLE);

`ifdef LED_SEQ_GAMMA_EN
  assign duty_eff = PWM_W'(gamma_map(16'(duty_q), PWM_W));
`else
  assign duty_eff = duty_q;
`endif

  led_pwm_gen #(.PWM_W(PWM_W)) u_pwm (
    .clk        (clk),
    .rst        (rst),
    .en         (busy_w),
    .duty_eff   (duty_eff),
    .pwm        (pwm),
    .period_end (period_end)
  );

  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    cur_ch_d    = cur_ch_q;
    hold_d      = hold_q;
    stop_pend_d = stop_pend_q || (busy_w && stop);
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d  = S_UP;
          duty_d   = '0;
          cur_ch_d = '0;
          hold_d   = '0;
        end
      end
      S_UP: if (period_end) begin
        if (stop_pend_q) begin
          state_d = S_DOWN;               // ramp down from the current duty
        end else if (duty_q == PWM_W'(DUTY_MAX)) begin
          hold_d  = '0;
          state_d = NO_HOLD ? S_DOWN : S_HOLD;
        end else begin
          duty_d = duty_q + 1'b1;
        end
      end
      S_HOLD: if (period_end) begin
        if (stop_pend_q || hold_q == HW'(HOLD_PER - 1)) state_d = S_DOWN;
        else                                            hold_d  = hold_q + 1'b1;
      end
      S_DOWN: if (period_end) begin
        if (duty_q != '0) begin
          duty_d = duty_q - 1'b1;
        end else if (stop_pend_q) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end else begin
          // the duty-0 period just finished is the dark gap between channels
          cur_ch_d = (cur_ch_q == CW'(N_CH - 1)) ? '0 : cur_ch_q + 1'b1;
          state_d  = S_UP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      duty_q      <= '0;
      cur_ch_q    <= '0;
      hold_q      <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      cur_ch_q    <= cur_ch_d;
      hold_q      <= hold_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
    end
  end

  // The PWM bit is already registered. cur_ch only changes at edges where the
  // compare was forced low (duty 0 at the end of DOWN, or leaving IDLE), so
  // steering it with the current cur_ch matches per-lane registered drive.
  for (genvar i = 0; i < N_CH; i++) begin : g_led
    assign led[i] = pwm && (cur_ch_q == CW'(i));
  end

  assign busy   = busy_w;
  assign cur_ch = cur_ch_q;
  assign duty   = duty_q;
  assign done   = done_q;

endmodule

// File: tb/tb_led_breath_seq.sv
module tb_led_breath_seq;

  localparam int N_CH = 2, PWM_W = 3, DUTY_MAX = 7, HOLD_PER = 2;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
  logic [1:0] led;
  logic       busy, done;
  logic [0:0] cur_ch;
  logic [2:0] duty;

  led_breath_seq #(.N_CH(N_CH), .PWM_W(PWM_W), .DUTY_MAX(DUTY_MAX), .HOLD_PER(HOLD_PER)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .led(led), .busy(busy), .cur_ch(cur_ch), .duty(duty), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] led;
    logic       busy;
    logic [0:0] ch;
    logic [2:0] duty;
    logic       done;
  } exp_t;

  exp_t sbq[$];
  int   vecs = 0, errs = 0, done_cnt = 0;

  function automatic int eff(int d);
`ifdef LED_SEQ_GAMMA_EN
    return (d * d) >> 3;
`else
    return d;
`endif
  endfunction

  // Reference model: 0=IDLE 1=UP 2=HOLD 3=DOWN; pushes expected outputs each edge
  int       m_st = 0, m_duty = 0, m_ch = 0, m_hold = 0, m_cnt = 0;
  bit       m_pend = 0, m_done = 0;
  logic [1:0] m_led = '0;

  always @(posedge clk) begin : model
    exp_t e;
    bit   pe, pend_n;
    if (rst) begin
      m_st = 0; m_duty = 0; m_ch = 0; m_hold = 0; m_cnt = 0;
      m_pend = 0; m_done = 0; m_led = '0;
    end else begin
      m_led = '0;
      if (m_st != 0 && m_cnt < eff(m_duty)) m_led[m_ch] = 1'b1;
      m_done = 0;
      pe     = (m_cnt == 7);
      pend_n = m_pend || ((m_st != 0) && stop);
      case (m_st)
        0: begin
          pend_n = 0;
          if (start && !stop) begin m_st = 1; m_duty = 0; m_ch = 0; m_hold = 0; end
        end
        1: if (pe) begin
          if (m_pend) m_st = 3;
          else if (m_duty == DUTY_MAX) begin m_hold = 0; m_st = 2; end
          else m_duty++;
        end
        2: if (pe) begin
          if (m_pend || m_hold == HOLD_PER - 1) m_st = 3;
          else m_hold++;
        end
        default: if (pe) begin
          if (m_duty != 0) m_duty--;
          else if (m_pend) begin m_st = 0; m_done = 1; pend_n = 0; end
          else begin m_ch = (m_ch == N_CH - 1) ? 0 : m_ch + 1; m_st = 1; end
        end
      endcase
      m_pend = pend_n;
      m_cnt  = (m_cnt + 1) % 8;
    end
    e.led = m_led; e.busy = (m_st != 0); e.ch = 1'(m_ch);
    e.duty = 3'(m_duty); e.done = m_done;
    sbq.push_back(e);
  end

  // Advance to the next falling edge and check the scoreboard there
  task automatic tick();
    exp_t e, o;
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      o = {led, busy, cur_ch, duty, done};
      vecs++;
      assert (o === e) else begin
        errs++;
        $error("FAIL sb t=%0t observed=%h expected=%h", $time, o, e);
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_duty(input int k, input int ch);
    bit ok = 0;
    for (int i = 0; i < 600; i++) begin
      if (busy === 1'b1 && duty === 3'(k) && cur_ch === 1'(ch)) begin ok = 1; break; end
      tick();
    end
    chk($sformatf("wait_duty%0d_ch%0d", k, ch), int'(ok), 1);
  endtask

  initial begin
    int hi0, hi1, n7, n0;
    bit seen;
    // reset and idle
    repeat (3) tick();
    rst = 1'b0;
    repeat (50) tick();
    chk("idle_busy", int'(busy), 0);
    chk("idle_led", int'(led), 0);
    chk("idle_duty", int'(duty), 0);
    chk("idle_done_cnt", done_cnt, 0);

    // start: busy next clk on ch0
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", int'(busy), 1);
    chk("start_ch", int'(cur_ch), 0);
    chk("start_duty", int'(duty), 0);

    // UP ramp: per period led[0] high for eff(duty) clocks, led[1] dark
    for (int k = 1; k <= 7; k++) begin
      wait_duty(k, 0);
      hi0 = 0; hi1 = 0;
      for (int j = 0; j < 8; j++) begin
        hi0 += int'(led[0]); hi1 += int'(led[1]);
        tick();
      end
      chk($sformatf("up_led0_d%0d", k), hi0, eff(k));
      chk($sformatf("up_led1_d%0d", k), hi1, 0);
    end

    // duty 7 spans last UP period + 2 HOLD + first DOWN period
    n7 = 8;
    for (int i = 0; i < 100 && duty === 3'd7; i++) begin n7++; tick(); end
    chk("peak_len", n7, 32);
    chk("down_first", int'(duty), 6);

    // one dark period, then ch1
    wait_duty(0, 0);
    n0 = 0;
    for (int i = 0; i < 50 && cur_ch === 1'b0; i++) begin n0++; tick(); end
    chk("dark_len", n0, 8);
    chk("next_ch", int'(cur_ch), 1);
    chk("next_duty", int'(duty), 0);

    // ch1 breathes, then wrap to ch0
    wait_duty(7, 1);
    for (int i = 0; i < 300 && cur_ch !== 1'b0; i++) tick();
    chk("wrap_ch", int'(cur_ch), 0);
    chk("wrap_busy", int'(busy), 1);
    chk("wrap_duty", int'(duty), 0);

    // start while busy is ignored
    wait_duty(2, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy_ign", int'(busy), 1);
    chk("start_busy_ch", int'(cur_ch), 0);

    // stop during HOLD of ch0
    wait_duty(7, 0);
    repeat (10) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin seen = 1; break; end
      tick();
    end
    chk("done_seen", int'(seen), 1);
    chk("done_busy", int'(busy), 0);
    chk("done_ch", int'(cur_ch), 0);
    chk("done_duty", int'(duty), 0);
    tick();
    chk("done_pulse_w", int'(done), 0);
    chk("done_cnt", done_cnt, 1);

    // stop alone and start+stop in IDLE are ignored
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (5) tick();
    chk("stop_idle", int'(busy), 0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    repeat (20) tick();
    chk("startstop_busy", int'(busy), 0);
    chk("startstop_led", int'(led), 0);

    // reset mid-UP at duty 4
    start = 1'b1; tick(); start = 1'b0;
    wait_duty(4, 0);
    repeat (3) tick();
    rst = 1'b1; tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_ch", int'(cur_ch), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_busy", int'(busy), 0);
    chk("total_done", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
